// File: rtl/spi_slave_interface_pkg.sv
// spi_defs: shared SPI mode-0 constants, byte width and FSM state encoding
package spi_defs;

  localparam int BYTE_W = 8;
  localparam int BIT_W  = $clog2(BYTE_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_slave_interface_if.sv
// spi_slave_interface_if: SPI pins plus the byte handshake towards the command logic
interface spi_slave_interface_if;

  logic                      SCK_C;
  logic                      CS_S;
  logic                      MOSI_DQ0;
  logic                      MISO_DQ1;
  logic                      miso_oe;
  logic [spi_defs::BYTE_W-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_load;
  logic [spi_defs::BYTE_W-1:0] rx_data;
  logic                      rx_valid;
  logic [spi_defs::BYTE_W-1:0] byte_count;
  logic                      busy;

  modport slave (
    input  SCK_C, CS_S, MOSI_DQ0, tx_data, tx_valid,
    output MISO_DQ1, miso_oe, tx_load, rx_data, rx_valid, byte_count, busy
  );

  modport master (
    output SCK_C, CS_S, MOSI_DQ0, tx_data, tx_valid,
    input  MISO_DQ1, miso_oe, tx_load, rx_data, rx_valid, byte_count, busy
  );

endinterface

// File: rtl/spi_slave_interface_sync.sv
// spi_input_sync: multi-stage synchroniser with rise/fall detect on the last two synced samples
module spi_input_sync #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]             prev_q;

  // Reset low: a CS already low when reset releases must not look like a falling edge.
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_interface.sv
// spi_slave_interface: SPI mode-0 responder oversampled in clk_in, byte strobes and byte counter
module spi_slave_interface
  import spi_defs::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_TX     = 8'hFF
) (
  input logic                  clk_in,
  input logic                  reset_n,
  spi_slave_interface_if.slave bus
);

  logic [1:0]        ctl_rise, ctl_fall, unused_ctl_lvl;
  logic              mosi, unused_mosi_rise, unused_mosi_fall;
  logic              sck_rise, sck_fall, cs_rise, cs_fall;
  logic [BYTE_W-1:0] load_d, rx_byte_d;

  state_e            state_q;
  logic [BYTE_W-2:0] rx_sh_q;
  logic [BYTE_W-1:0] tx_sh_q, rx_data_q, byte_count_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              byte_done_q, rx_valid_q, tx_load_q, busy_q, miso_oe_q;

  spi_input_sync #(.STAGES(SYNC_STAGES), .W(2)) u_ctl_sync (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .d_i    ({bus.CS_S, bus.SCK_C}),
    .q_o    (unused_ctl_lvl),
    .rise_o (ctl_rise),
    .fall_o (ctl_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .W(1)) u_mosi_sync (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .d_i    (bus.MOSI_DQ0),
    .q_o    (mosi),
    .rise_o (unused_mosi_rise),
    .fall_o (unused_mosi_fall)
  );

  assign {cs_rise, sck_rise} = ctl_rise;
  assign {cs_fall, sck_fall} = ctl_fall;
  assign load_d              = bus.tx_valid ? bus.tx_data : IDLE_TX;
  assign rx_byte_d           = {rx_sh_q, mosi};

  // MISO is the top bit of the tx shifter; filling it with ones idles the line high.
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rx_sh_q      <= '0;
      tx_sh_q      <= '1;
      rx_data_q    <= '0;
      byte_count_q <= '0;
      bit_cnt_q    <= BIT_LAST;
      byte_done_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (cs_fall) begin
          state_q      <= ST_ACTIVE;
          busy_q       <= 1'b1;
          miso_oe_q    <= 1'b1;
          bit_cnt_q    <= BIT_LAST;
          byte_count_q <= '0;
          byte_done_q  <= 1'b0;
          tx_sh_q      <= load_d;
          tx_load_q    <= bus.tx_valid;
        end
      end else if (cs_rise) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        miso_oe_q   <= 1'b0;
        byte_done_q <= 1'b0;
        bit_cnt_q   <= BIT_LAST;
        tx_sh_q     <= '1;
      end else if (sck_rise) begin
        rx_sh_q <= rx_byte_d[BYTE_W-2:0];
        if (bit_cnt_q == '0) begin
          rx_data_q    <= rx_byte_d;
          rx_valid_q   <= 1'b1;
          byte_count_q <= sat_inc(byte_count_q);
          bit_cnt_q    <= BIT_LAST;
          byte_done_q  <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q - 1'b1;
        end
      end else if (sck_fall) begin
        if (byte_done_q) begin
          tx_sh_q     <= load_d;
          tx_load_q   <= bus.tx_valid;
          byte_done_q <= 1'b0;
        end else begin
          tx_sh_q <= {tx_sh_q[BYTE_W-2:0], 1'b1};
        end
      end
    end

  assign bus.MISO_DQ1   = tx_sh_q[BYTE_W-1];
  assign bus.miso_oe    = miso_oe_q;
  assign bus.tx_load    = tx_load_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.byte_count = byte_count_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spi_slave_interface.sv
// tb_spi_slave_interface: directed and random SPI master transfers checked against a byte-level model
module tb_spi_slave_interface;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spi_slave_interface_if ifc ();

  spi_slave_interface #(.SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .clk_in (clk),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mosi_buf [0:299];
  logic [7:0] tx_buf   [0:299];
  logic [7:0] miso_got [0:299];
  logic [7:0] rx_arr   [0:299];
  logic [7:0] last_rx;
  int   tx_n, tx_idx, tx_loads, rx_cnt;
  logic clr, mid_busy;

  // Command-logic stand-in: offers tx_buf in order, advancing on each tx_load.
  assign ifc.tx_valid = tx_idx < tx_n;
  assign ifc.tx_data  = (tx_idx < tx_n) ? tx_buf[tx_idx] : 8'h00;

  always @(posedge clk)
    if (clr) begin
      tx_idx   <= 0;
      tx_loads <= 0;
      rx_cnt   <= 0;
    end else begin
      if (ifc.tx_load) begin
        tx_idx   <= tx_idx + 1;
        tx_loads <= tx_loads + 1;
      end
      if (ifc.rx_valid && rx_cnt < 300) begin
        rx_arr[rx_cnt] <= ifc.rx_data;
        rx_cnt         <= rx_cnt + 1;
      end
    end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // Mode-0 master: MOSI changes on SCK fall, MISO sampled 2 cycles after each fall
  // (before the responder's synchronised update can replace the bit).
  task automatic run(input int n, input int h);
    int k;
    logic [7:0] m;
    mid_busy     = 1'b0;
    ifc.MOSI_DQ0 = mosi_buf[0][7];
    ifc.CS_S     = 1'b0;
    tick(h + 2);
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        ifc.SCK_C = 1'b1;
        tick(h);
        if (b == 0 && i == 3) mid_busy = ifc.busy;
        k = b * 8 + 8 - i;
        ifc.SCK_C = 1'b0;
        if (k < n * 8) ifc.MOSI_DQ0 = mosi_buf[k / 8][7 - k % 8];
        tick(2);
        m[i] = ifc.MISO_DQ1;
        tick(h - 2);
      end
      miso_got[b] = m;
    end
    tick(h);
    ifc.CS_S = 1'b1;
    tick(8);
  endtask

  task automatic check_run(input string tag, input int n);
    for (int b = 0; b < n; b++) begin
      chk({tag, "_rx"}, rx_arr[b], mosi_buf[b]);
      chk({tag, "_miso"}, miso_got[b], (b < tx_n) ? tx_buf[b] : 8'hFF);
    end
    chk({tag, "_rx_count"}, rx_cnt, n);
    chk({tag, "_byte_count"}, ifc.byte_count, (n > 255) ? 255 : n);
    chk({tag, "_tx_loads"}, tx_loads, (n + 1 < tx_n) ? n + 1 : tx_n);
    chk({tag, "_rx_data"}, ifc.rx_data, mosi_buf[n - 1]);
    chk({tag, "_busy_mid"}, mid_busy, 1);
    chk({tag, "_idle_pins"}, {ifc.busy, ifc.miso_oe, ifc.MISO_DQ1}, 3'b001);
    last_rx = mosi_buf[n - 1];
  endtask

  initial begin
    reset_n      = 1'b0;
    ifc.CS_S     = 1'b1;
    ifc.SCK_C    = 1'b0;
    ifc.MOSI_DQ0 = 1'b0;
    clr          = 1'b1;
    tx_n         = 0;
    tick(3);
    chk("rst_miso", ifc.MISO_DQ1, 1);
    chk("rst_oe", ifc.miso_oe, 0);
    chk("rst_tx_load", ifc.tx_load, 0);
    chk("rst_rx_data", ifc.rx_data, 0);
    chk("rst_rx_valid", ifc.rx_valid, 0);
    chk("rst_byte_count", ifc.byte_count, 0);
    chk("rst_busy", ifc.busy, 0);
    reset_n = 1'b1;
    tick(4);
    clr = 1'b0;

    tx_buf[0] = 8'hA5; tx_n = 1; mosi_buf[0] = 8'h3C;
    clear();
    run(1, 4);
    check_run("single", 1);

    mosi_buf[0] = 8'h01; mosi_buf[1] = 8'h02; mosi_buf[2] = 8'h03;
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h82; tx_buf[2] = 8'h83; tx_n = 3;
    clear();
    run(3, 4);
    check_run("burst", 3);

    tx_n = 0; mosi_buf[0] = 8'h55;
    clear();
    run(1, 4);
    check_run("underrun", 1);

    clear();
    ifc.CS_S = 1'b0;
    tick(4);
    for (int e = 0; e < 5; e++) begin
      ifc.SCK_C = ~ifc.SCK_C;
      tick(4);
    end
    ifc.SCK_C = 1'b0;
    ifc.CS_S  = 1'b1;
    tick(8);
    chk("partial_rx_count", rx_cnt, 0);
    chk("partial_rx_data", ifc.rx_data, last_rx);
    chk("partial_byte_count", ifc.byte_count, 0);
    chk("partial_idle_pins", {ifc.busy, ifc.miso_oe, ifc.MISO_DQ1}, 3'b001);
    mosi_buf[0] = 8'h99;
    clear();
    run(1, 4);
    check_run("after_partial", 1);

    clear();
    ifc.CS_S = 1'b0;
    tick(4);
    repeat (3) begin
      ifc.SCK_C = 1'b1; tick(4);
      ifc.SCK_C = 1'b0; tick(4);
    end
    ifc.SCK_C = 1'b1;
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("midrst_pins", {ifc.busy, ifc.miso_oe, ifc.MISO_DQ1}, 3'b001);
    chk("midrst_rx_data", ifc.rx_data, 0);
    chk("midrst_byte_count", ifc.byte_count, 0);
    tick(2);
    reset_n   = 1'b1;
    ifc.SCK_C = 1'b0;
    tick(4);
    repeat (8) begin
      ifc.SCK_C = 1'b1; tick(4);
      ifc.SCK_C = 1'b0; tick(4);
    end
    chk("cs_held_rx_count", rx_cnt, 0);
    chk("cs_held_tx_loads", tx_loads, 0);
    chk("cs_held_pins", {ifc.busy, ifc.miso_oe, ifc.MISO_DQ1}, 3'b001);
    ifc.CS_S = 1'b1;
    tick(8);
    mosi_buf[0] = 8'h5A; tx_buf[0] = 8'hC3; tx_n = 1;
    clear();
    run(1, 4);
    check_run("after_reset", 1);

    for (int i = 0; i < 17; i++) begin
      mosi_buf[i] = 8'($urandom);
      tx_buf[i]   = 8'($urandom);
    end
    tx_n = $urandom_range(10, 17);
    clear();
    run(16, 2);
    check_run("fast_random", 16);

    for (int i = 0; i < 256; i++) mosi_buf[i] = 8'($urandom);
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h34; tx_n = 2;
    clear();
    run(256, 2);
    check_run("saturate", 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
